// File: rtl/pipe_skid_reg.sv
// Elastic two-entry pipeline register (main + skid) with valid/ready on both sides.
// All outputs are decoded from registers only, so stalls do not create long comb paths
// between adjacent pipeline stages.
module pipe_skid_reg #(
  parameter int unsigned DATA_W   = 69,
  parameter int unsigned CTRL_W   = 4,
  parameter bit          CLR_CTRL = 1'b1
) (
  input  logic              clk_i,
  input  logic              start_i,
  input  logic              flush_i,
  input  logic              up_valid_i,
  output logic              up_ready_o,
  input  logic [CTRL_W-1:0] up_ctrl_i,
  input  logic [DATA_W-1:0] up_data_i,
  output logic              dn_valid_o,
  input  logic              dn_ready_i,
  output logic [CTRL_W-1:0] dn_ctrl_o,
  output logic [DATA_W-1:0] dn_data_o,
  output logic [1:0]        occ_o
);

  // Encoding equals occupancy, so occ_o is the state register itself.
  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [CTRL_W-1:0] main_ctrl_q, skid_ctrl_q;
  logic [DATA_W-1:0] main_data_q, skid_data_q;

  logic main_valid, stage_ready;
  logic accept, send;
  logic ld_main_up, ld_main_skid, ld_skid_up, clr_main_ctrl, clr_skid_ctrl;

  assign main_valid  = (state_q != StEmpty);
  assign stage_ready = (state_q != StFull);
  assign accept      = up_valid_i & stage_ready;
  assign send        = main_valid & dn_ready_i;

  // State register; reset wins over everything else.
  always_ff @(posedge clk_i) begin
    if (!start_i) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: occupancy bookkeeping, flush collapses to empty.
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: if (accept) state_d = StOne;
        StOne: begin
          if (send && !accept)      state_d = StEmpty;
          else if (accept && !send) state_d = StFull;
        end
        StFull:  if (send) state_d = StOne;
        default: state_d = StEmpty;
      endcase
    end
  end

  // Output decode: purely from registers.
  always_comb begin
    up_ready_o = stage_ready;
    dn_valid_o = main_valid;
    dn_ctrl_o  = main_ctrl_q;
    dn_data_o  = main_data_q;
    occ_o      = state_q;
  end

  // Datapath steering. Loads are gated by accept so X on idle upstream payload never enters.
  always_comb begin
    ld_main_up    = !flush_i && accept && ((state_q == StEmpty) || send);
    ld_main_skid  = !flush_i && send && (state_q == StFull);
    ld_skid_up    = !flush_i && accept && !send && (state_q == StOne);
    // Any move to "no valid beat" turns the exposed control into a NOP.
    clr_main_ctrl = CLR_CTRL && (state_d == StEmpty);
    clr_skid_ctrl = CLR_CTRL && flush_i;
  end

  // Main register: refilled from upstream or from skid; ctrl cleared on bubble.
  always_ff @(posedge clk_i) begin
    if (!start_i) begin
      main_ctrl_q <= '0;
      main_data_q <= '0;
    end else begin
      if (ld_main_up) begin
        main_data_q <= up_data_i;
      end else if (ld_main_skid) begin
        main_data_q <= skid_data_q;
      end
      if (clr_main_ctrl) begin
        main_ctrl_q <= '0;
      end else if (ld_main_up) begin
        main_ctrl_q <= up_ctrl_i;
      end else if (ld_main_skid) begin
        main_ctrl_q <= skid_ctrl_q;
      end
    end
  end

  // Skid register: catches the beat that arrives while main is stalled.
  always_ff @(posedge clk_i) begin
    if (!start_i) begin
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
    end else begin
      if (ld_skid_up) begin
        skid_data_q <= up_data_i;
      end
      if (clr_skid_ctrl) begin
        skid_ctrl_q <= '0;
      end else if (ld_skid_up) begin
        skid_ctrl_q <= up_ctrl_i;
      end
    end
  end

endmodule
